// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared types and helpers for the traffic phase controller.
//   light_t          : 2-bit per-phase light code (00 red, 01 yellow, 10 green)
//   state_t          : controller sequencing states
//   pack_phase_light : places one phase's light code into an otherwise-red
//                      lights vector sized for the largest supported phase count
// -----------------------------------------------------------------------------
package traffic_pkg;

  localparam int MAX_PHASES = 8;

  // Literal names carry a prefix because light_t and state_t both need
  // GREEN/YELLOW and share one package namespace.
  typedef enum logic [1:0] {
    LT_RED    = 2'b00,
    LT_YELLOW = 2'b01,
    LT_GREEN  = 2'b10
  } light_t;

  typedef enum logic [1:0] {
    S_ALL_RED = 2'd0,
    S_GREEN   = 2'd1,
    S_YELLOW  = 2'd2
  } state_t;

  // Every phase other than 'phase' is red; the caller trims to its own width.
  function automatic logic [2*MAX_PHASES-1:0] pack_phase_light(
    input logic [2:0] phase,
    input light_t     light
  );
    logic [2*MAX_PHASES-1:0] vec;
    vec = '0;
    vec[2*phase +: 2] = light;
    return vec;
  endfunction

endpackage

// File: rtl/rr_next_phase.sv
// -----------------------------------------------------------------------------
// rr_next_phase
// Combinational round-robin search: finds the first requesting phase after
// 'last', wrapping around. The search ends on 'last' itself, so a lone
// request from the last-granted phase is still found.
// Ports:
//   req   [NUM_PHASES-1:0]        : per-phase request vector
//   last  [$clog2(NUM_PHASES)-1:0]: most recently granted phase
//   next  [$clog2(NUM_PHASES)-1:0]: selected phase (0 when valid is low)
//   valid                         : at least one request present
// -----------------------------------------------------------------------------
module rr_next_phase #(
  parameter int NUM_PHASES = 3
) (
  input  logic [NUM_PHASES-1:0]         req,
  input  logic [$clog2(NUM_PHASES)-1:0] last,
  output logic [$clog2(NUM_PHASES)-1:0] next,
  output logic                          valid
);

  localparam int PW = $clog2(NUM_PHASES);

  int idx;

  always_comb begin
    next  = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_PHASES; i++) begin
      idx = (int'(last) + i) % NUM_PHASES;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        next  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_phase_ctrl
// N-phase traffic-light controller. One phase at a time is sequenced through
// GREEN -> YELLOW -> ALL_RED, with min/max green timing driven by per-phase
// vehicle sensors and round-robin selection of the next phase.
//
// Optional build macro: TRAFFIC_PREEMPT_EN adds an emergency preemption input
// pair (preempt, preempt_phase). Without it the ports do not exist.
//
// Ports:
//   clk            : system clock
//   reset          : synchronous, active-high
//   sensor         : per-phase vehicle request, level-sensitive
//   preempt        : (TRAFFIC_PREEMPT_EN) preemption request
//   preempt_phase  : (TRAFFIC_PREEMPT_EN) phase to be served under preemption
//   lights         : phase p on bits [2p+1:2p]; 10 green, 01 yellow, 00 red
//   cur_phase      : granted / last-granted phase
//   busy           : high in GREEN or YELLOW
// -----------------------------------------------------------------------------
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES  = 3,
  parameter int GREEN_MIN   = 4,
  parameter int GREEN_MAX   = 10,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PHASES-1:0]         sensor,
`ifdef TRAFFIC_PREEMPT_EN
  input  logic                          preempt,
  input  logic [$clog2(NUM_PHASES)-1:0] preempt_phase,
`endif
  output logic [2*NUM_PHASES-1:0]       lights,
  output logic [$clog2(NUM_PHASES)-1:0] cur_phase,
  output logic                          busy
);

  localparam int PW = $clog2(NUM_PHASES);
  localparam int TW = $clog2(GREEN_MAX + 1);

  // Terminal counts: each state ends on the cycle its counter reaches these.
  localparam logic [TW-1:0] AR_LAST  = TW'(ALLRED_TIME - 1);
  localparam logic [TW-1:0] Y_LAST   = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] GMIN_M1  = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] GMAX_M1  = TW'(GREEN_MAX - 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [TW-1:0]   count_q, count_d;

  logic [NUM_PHASES-1:0] own_mask;
  logic                  own_req;
  logic                  other_req;
  logic                  go_yellow;

  logic [PW-1:0]   rr_next;
  logic            rr_valid;
  logic            grant_v;
  logic [PW-1:0]   grant_p;

`ifdef TRAFFIC_PREEMPT_EN
  // Remembers which phase a preemption cut short for, so the following
  // ALL_RED still serves it even if preempt is released during clearance.
  logic            pend_q, pend_d;
  logic [PW-1:0]   pend_phase_q, pend_phase_d;
`endif

  rr_next_phase #(
    .NUM_PHASES (NUM_PHASES)
  ) u_rr (
    .req   (sensor),
    .last  (phase_q),
    .next  (rr_next),
    .valid (rr_valid)
  );

  assign own_mask  = NUM_PHASES'(1) << phase_q;
  assign own_req   = sensor[phase_q];
  assign other_req = |(sensor & ~own_mask);

  // Phase to serve at the ALL_RED decision point.
  always_comb begin
    grant_v = rr_valid;
    grant_p = rr_next;
`ifdef TRAFFIC_PREEMPT_EN
    if (preempt) begin
      grant_v = 1'b1;
      grant_p = preempt_phase;
    end else if (pend_q) begin
      grant_v = 1'b1;
      grant_p = pend_phase_q;
    end
`endif
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    count_d   = count_q;
    go_yellow = 1'b0;
`ifdef TRAFFIC_PREEMPT_EN
    pend_d       = pend_q;
    pend_phase_d = pend_phase_q;
`endif
    case (state_q)
      S_ALL_RED: begin
        if (count_q != AR_LAST) begin
          count_d = count_q + 1'b1;
        end else if (grant_v) begin
          state_d = S_GREEN;
          phase_d = grant_p;
          count_d = '0;
`ifdef TRAFFIC_PREEMPT_EN
          pend_d  = 1'b0;
`endif
        end
        // No request: idle in all-red with the counter held at its terminal.
      end

      S_GREEN: begin
        if (count_q != GMAX_M1) begin
          count_d = count_q + 1'b1;
        end
        // Gap-out needs the served phase to have gone quiet; max-out does not.
        go_yellow = (other_req && !own_req && (count_q >= GMIN_M1)) ||
                    (other_req && (count_q == GMAX_M1));
`ifdef TRAFFIC_PREEMPT_EN
        if (preempt) begin
          go_yellow = (phase_q != preempt_phase);
          if (phase_q != preempt_phase) begin
            pend_d       = 1'b1;
            pend_phase_d = preempt_phase;
          end
        end
`endif
        if (go_yellow) begin
          state_d = S_YELLOW;
          count_d = '0;
        end
      end

      S_YELLOW: begin
        if (count_q == Y_LAST) begin
          state_d = S_ALL_RED;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      default: begin
        state_d = S_ALL_RED;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ALL_RED;
      phase_q <= PW'(NUM_PHASES - 1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      count_q <= count_d;
    end
  end

`ifdef TRAFFIC_PREEMPT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q       <= 1'b0;
      pend_phase_q <= '0;
    end else begin
      pend_q       <= pend_d;
      pend_phase_q <= pend_phase_d;
    end
  end
`endif

  // Moore output decode: only the served phase can be non-red.
  always_comb begin
    lights = '0;
    case (state_q)
      S_GREEN:  lights = (2*NUM_PHASES)'(pack_phase_light(3'(phase_q), LT_GREEN));
      S_YELLOW: lights = (2*NUM_PHASES)'(pack_phase_light(3'(phase_q), LT_YELLOW));
      default:  lights = '0;
    endcase
  end

  assign busy      = (state_q == S_GREEN) || (state_q == S_YELLOW);
  assign cur_phase = phase_q;

endmodule
